gf_sbox_share_arb: RTL and testbench
====================================

// Module: gf_sbox_share_arb
// PURPOSE
//  - Shares one pipelined composite-field AES S-box (GF(2^4)/GF(2^2) tower built from gf_mul_2 cells)
//    between NREQ requesters, e.g. round SubBytes lanes and key-expansion SubWord.
//  - Round-robin arbitration with a valid/ready request side.
//  - Carries a one-hot owner tag through a pipe matched to the S-box latency; returns each result
//    to its owner as a one-cycle response pulse.
//  - Sits between the AES round controller and the shared gf_s_box instance.
// PARAMETERS
//  NREQ      4   number of requesters, 2..8
//  DW        8   byte width, fixed at 8
//  SBOX_LAT  2   pipeline latency of the shared S-box in clk cycles, 1..4
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  req_valid  in   NREQ      requester i has a byte pending
//  req_data   in   NREQ*DW   byte of requester i at bits [i*DW +: DW]
//  req_ready  out  NREQ      one-hot grant; transfer when req_valid[i] & req_ready[i]
//  rsp_valid  out  NREQ      one-cycle pulse: result for requester i
//  rsp_data   out  DW        result byte, valid with any rsp_valid bit
//  sbox_x     out  DW        byte to shared S-box input (registered)
//  sbox_y     in   DW        S-box output, SBOX_LAT cycles after sbox_x was launched
//  busy       out  1         any tag in flight or any req_valid high
// BEHAVIOUR
//  - Reset (async assert, sync release): req_ready=0, rsp_valid=0, rsp_data=0, sbox_x=0, busy=0.
//    Round-robin pointer = 0; tag pipe cleared.
//  - Grant, combinational: scan from ptr upward, modulo NREQ; first i with req_valid[i] wins.
//    - req_ready is one-hot or zero.
//    - req_ready never asserts without the matching req_valid.
//  - On a transfer, at the next edge:
//    - sbox_x <= req_data[i].
//    - tag stage0 <= {1'b1, onehot(i)}.
//    - ptr <= (i+1) mod NREQ.
//  - No transfer: sbox_x <= 0, stage0 valid = 0, ptr holds.
//  - Tag pipe has SBOX_LAT stages after stage0.
//    - When the last stage is valid, that cycle: rsp_valid = its one-hot and rsp_data = sbox_y.
//  - Latency: request-accept edge to rsp_valid = SBOX_LAT+1 cycles.
//    Throughput: one byte per cycle total.
//  - Fairness: with all NREQ requesters continuously valid, each is granted exactly once every NREQ cycles.
//  - No response backpressure: a requester must accept rsp_valid in the cycle it occurs.
//  - A requester may keep req_valid high after a transfer.
//    - Each transfer is an independent byte; results return in grant order.
//  - A single-requester stream gets one grant per cycle while others are idle (pointer wraps to it).
//  - Reset mid-operation clears all in-flight tags; no rsp_valid is produced for lost bytes.
//  - busy is a registered OR of the tag-pipe valids, ORed combinationally with |req_valid.
// CONFIGURATION
//  - Macro GF_SBOX_ARB_INV_EN.
//  - Defined: adds input req_inv[NREQ] and output sbox_inv.
//    - req_inv is sampled with the transfer.
//    - sbox_inv is registered alongside sbox_x and selects the inverse S-box for that byte.
//    - sbox_inv reset value is 0.
//  - Not defined: neither port exists; every byte uses the forward S-box.
// STRUCTURE
//  - Package gf_sbox_pkg:
//    - localparam SBOX_DW=8.
//    - MAX_REQ=8.
//    - typedef for the tag struct {valid, owner[MAX_REQ-1:0], inv}.
//    - Known-answer constants for the bench.
//  - Sub-module rr_arbiter (NREQ): combinational one-hot grant from req and ptr.
//    - Pointer register stays in gf_sbox_share_arb.
//  - Tag pipe and sbox_x register are local; the S-box itself is not instantiated here.
// TESTING (bench S-box model with SBOX_LAT=2)
//  - Reset, then req_valid=4'b0001, req_data[7:0]=8'h00 for one cycle.
//    -> 3 cycles later rsp_valid=4'b0001, rsp_data=8'h63.
//  - All four valid with bytes 00/53/01/FF held for 8 cycles.
//    -> grants cycle 0,1,2,3,0,1,2,3.
//    -> responses 63,ED,7C,16 repeat in the same order.
//  - Only req 2 valid for 5 cycles with byte 8'h53.
//    -> req_ready=4'b0100 every cycle; 5 consecutive rsp pulses of ED.
//  - Assert rst_n=0 with 2 bytes in flight.
//    -> no rsp_valid after release; sbox_x=0; ptr=0.
//    -> first post-reset grant goes to the lowest valid index.
//  - GF_SBOX_ARB_INV_EN defined, req 1 sends 8'h63 with req_inv=1.
//    -> sbox_inv=1 alongside sbox_x=63; rsp_data=8'h00 on rsp_valid=4'b0010.
//  - Random valid/data for 10k cycles vs scoreboard.
//    -> every accepted byte returns exactly once to its owner.
//    -> no grant without valid; max wait < NREQ cycles.

Source files
------------

// File: rtl/gf_sbox_pkg.sv
// Shared definitions for the composite-field S-box sharing arbiter.
// Optional feature macro: GF_SBOX_ARB_INV_EN (per-byte inverse S-box select).
package gf_sbox_pkg;

    localparam int SBOX_DW = 8;
    localparam int MAX_REQ = 8;

    // Owner tag that travels alongside each byte through the S-box latency.
    typedef struct packed {
        logic               valid;
        logic [MAX_REQ-1:0] owner;
        logic               inv;
    } tag_t;

    // Known-answer pairs of the forward AES S-box.
    localparam logic [SBOX_DW-1:0] KAT_X0 = 8'h00, KAT_Y0 = 8'h63;
    localparam logic [SBOX_DW-1:0] KAT_X1 = 8'h53, KAT_Y1 = 8'hED;
    localparam logic [SBOX_DW-1:0] KAT_X2 = 8'h01, KAT_Y2 = 8'h7C;
    localparam logic [SBOX_DW-1:0] KAT_X3 = 8'hFF, KAT_Y3 = 8'h16;
    // Known-answer pair of the inverse S-box.
    localparam logic [SBOX_DW-1:0] KAT_IX0 = 8'h63, KAT_IY0 = 8'h00;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: lowest requester at or above ptr wins,
// otherwise the lowest requester overall (wrap-around). The pointer register
// itself lives in the parent.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);

    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] mask_hi;
    logic [NREQ-1:0] cand;

    // Restrict to requesters at/above ptr when any exist, then pick the lowest.
    always_comb begin
        mask_hi = {NREQ{1'b1}} << ptr;
        cand    = ((req & mask_hi) != '0) ? (req & mask_hi) : req;
        gnt     = '0;
        gnt_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                gnt     = NREQ'(1) << i;
                gnt_idx = PW'(i);
            end
        end
    end

endmodule

// File: rtl/gf_sbox_share_arb.sv
// Shares one pipelined AES S-box between NREQ requesters. Round-robin grant,
// registered S-box launch, and a one-hot owner tag pipe matched to the S-box
// latency so each result is returned to its owner as a one-cycle pulse.
// Optional feature macro: GF_SBOX_ARB_INV_EN adds req_inv / sbox_inv.
module gf_sbox_share_arb
    import gf_sbox_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int SBOX_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
`ifdef GF_SBOX_ARB_INV_EN
    input  logic [NREQ-1:0]    req_inv,
    output logic               sbox_inv,
`endif
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic [DW-1:0]      sbox_x,
    input  logic [DW-1:0]      sbox_y,
    output logic               busy
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            xfer;
    logic [DW-1:0]   sel_data;
    logic            sel_inv;
    logic            tags_busy;
    logic            unused_tag;
    tag_t            pipe [SBOX_LAT+1];

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    // Byte (and inverse select) of the granted requester.
    always_comb begin
        sel_data = '0;
        sel_inv  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_data = req_data[i*DW +: DW];
`ifdef GF_SBOX_ARB_INV_EN
                sel_inv  = req_inv[i];
`endif
            end
        end
    end

    // Launch register, round-robin pointer and owner tag pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            sbox_x <= '0;
`ifdef GF_SBOX_ARB_INV_EN
            sbox_inv <= 1'b0;
`endif
            for (int i = 0; i <= SBOX_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            if (xfer) begin
                sbox_x  <= sel_data;
                pipe[0] <= '{valid: 1'b1, owner: MAX_REQ'(gnt), inv: sel_inv};
                ptr     <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                sbox_x  <= '0;
                pipe[0] <= '0;
            end
`ifdef GF_SBOX_ARB_INV_EN
            sbox_inv <= xfer & sel_inv;
`endif
            for (int i = 1; i <= SBOX_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Anything still in the tag pipe keeps the block busy.
    always_comb begin
        tags_busy = 1'b0;
        for (int i = 0; i <= SBOX_LAT; i++) begin
            tags_busy = tags_busy | pipe[i].valid;
        end
    end

    assign busy      = tags_busy | (|req_valid);
    assign rsp_valid = pipe[SBOX_LAT].valid ? pipe[SBOX_LAT].owner[NREQ-1:0] : '0;
    assign rsp_data  = pipe[SBOX_LAT].valid ? sbox_y : '0;

    // The inverse flag already rode along on sbox_inv; the last stage only needs owner.
    assign unused_tag = ^pipe[SBOX_LAT];

endmodule

// File: tb/tb_gf_sbox_share_arb.sv
// Self-checking bench for gf_sbox_share_arb with a behavioural S-box model
// (SBOX_LAT=2) and a grant/response scoreboard.
module tb_gf_sbox_share_arb;
    import gf_sbox_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int LAT  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_inv;
    logic               sbox_inv;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic [DW-1:0]      sbox_x;
    logic [DW-1:0]      sbox_y;
    logic               busy;

    always #5 clk = ~clk;

    gf_sbox_share_arb #(.NREQ(NREQ), .DW(DW), .SBOX_LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef GF_SBOX_ARB_INV_EN
        .req_inv   (req_inv),
        .sbox_inv  (sbox_inv),
`endif
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .sbox_x    (sbox_x),
        .sbox_y    (sbox_y),
        .busy      (busy)
    );

`ifndef GF_SBOX_ARB_INV_EN
    assign sbox_inv = 1'b0;
`endif

    // ---------------- S-box reference tables (GF(2^8) arithmetic) ----------------
    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] g, input int n);
        return (g << n) | (g >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] g;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            g = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) g = 8'(y);
            end
            s = g ^ rotl(g, 1) ^ rotl(g, 2) ^ rotl(g, 3) ^ rotl(g, 4) ^ 8'h63;
            fwd_t[x] = s;
            inv_t[s] = 8'(x);
        end
    endtask

    // Shared S-box stand-in: LAT register stages after sbox_x.
    logic [7:0] sp [LAT];
    always @(posedge clk) begin
        sp[0] <= sbox_inv ? inv_t[sbox_x] : fwd_t[sbox_x];
        for (int i = 1; i < LAT; i++) sp[i] <= sp[i-1];
    end
    assign sbox_y = sp[LAT-1];

    // ---------------- scoreboard ----------------
    typedef struct {
        int              due;
        logic [NREQ-1:0] own;
        logic [7:0]      d;
    } exp_t;

    exp_t       q [$];
    logic [7:0] rsp_log [$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_g   = NREQ - 1;
    int         wt [NREQ];
    int         max_wait = 0;
    logic [7:0] exp_x    = 8'h00;
    logic       exp_xinv = 1'b0;
    logic [NREQ-1:0] last_ready;
    logic [NREQ-1:0] last_rsp_v;
    logic [7:0]      last_rsp_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check 1 ns later, update the model.
    task automatic cycle(input logic [NREQ-1:0] v, input logic [31:0] d, input logic [NREQ-1:0] iv);
        logic [NREQ-1:0] eg;
        int              eidx;
        int              j;
        exp_t            e;
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        req_inv   = iv;
        #1;
        eg   = '0;
        eidx = -1;
        for (int k = 1; k <= NREQ; k++) begin
            j = (last_g + k) % NREQ;
            if (eidx < 0 && v[j]) eidx = j;
        end
        if (eidx >= 0) eg[eidx] = 1'b1;
        chk("grant", 32'(req_ready), 32'(eg));
        chk("sbox_x", 32'(sbox_x), 32'(exp_x));
        chk("sbox_inv", 32'(sbox_inv), 32'(exp_xinv));
        chk("busy", 32'(busy), 32'((q.size() != 0) || (v != '0)));
        last_ready = req_ready;
        if (q.size() != 0 && q[0].due == cyc) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(q[0].own));
            chk("rsp_data", 32'(rsp_data), 32'(q[0].d));
            last_rsp_v = rsp_valid;
            last_rsp_d = rsp_data;
            rsp_log.push_back(rsp_data);
            void'(q.pop_front());
        end else begin
            chk("rsp_idle", 32'(rsp_valid), 32'h0);
        end
        if (eidx >= 0) begin
            exp_x    = d[eidx*8 +: 8];
`ifdef GF_SBOX_ARB_INV_EN
            exp_xinv = iv[eidx];
`else
            exp_xinv = 1'b0;
`endif
            e.due = cyc + LAT + 1;
            e.own = eg;
            e.d   = exp_xinv ? inv_t[exp_x] : fwd_t[exp_x];
            q.push_back(e);
            last_g = eidx;
        end else begin
            exp_x    = 8'h00;
            exp_xinv = 1'b0;
        end
        for (int k = 0; k < NREQ; k++) begin
            wt[k] = (v[k] && !eg[k]) ? wt[k] + 1 : 0;
            if (wt[k] > max_wait) max_wait = wt[k];
        end
        cyc++;
    endtask

    // Asynchronous reset mid-cycle, released on a falling edge.
    task automatic do_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        chk("rst_sbox_x", 32'(sbox_x), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_sbox_inv", 32'(sbox_inv), 32'h0);
        q.delete();
        last_g   = NREQ - 1;
        exp_x    = 8'h00;
        exp_xinv = 1'b0;
        for (int k = 0; k < NREQ; k++) wt[k] = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_inv   = '0;
        for (int k = 0; k < NREQ; k++) wt[k] = 0;
        build_tables();
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        // Single byte 00 from requester 0.
        last_rsp_v = '0;
        last_rsp_d = '0;
        cycle(4'b0001, 32'h0000_0000, 4'b0000);
        repeat (4) cycle(4'b0000, 32'h0, 4'b0000);
        chk("kat_single_v", 32'(last_rsp_v), 32'b0001);
        chk("kat_single_d", 32'(last_rsp_d), 32'(KAT_Y0));

        // All four valid: strict rotation and ordered responses.
        @(negedge clk);
        do_reset();
        rsp_log.delete();
        for (int k = 0; k < 8; k++) begin
            cycle(4'b1111, {KAT_X3, KAT_X2, KAT_X1, KAT_X0}, 4'b0000);
            chk("rr_grant", 32'(last_ready), 32'(4'b0001 << (k % 4)));
        end
        repeat (4) cycle(4'b0000, 32'h0, 4'b0000);
        chk("rr_rsp_count", 32'(rsp_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < rsp_log.size(); k++) begin
            case (k % 4)
                0: chk("rr_rsp0", 32'(rsp_log[k]), 32'(KAT_Y0));
                1: chk("rr_rsp1", 32'(rsp_log[k]), 32'(KAT_Y1));
                2: chk("rr_rsp2", 32'(rsp_log[k]), 32'(KAT_Y2));
                default: chk("rr_rsp3", 32'(rsp_log[k]), 32'(KAT_Y3));
            endcase
        end

        // Single-requester stream from requester 2.
        rsp_log.delete();
        for (int k = 0; k < 5; k++) begin
            cycle(4'b0100, {8'h00, KAT_X1, 8'h00, 8'h00}, 4'b0000);
            chk("solo_grant", 32'(last_ready), 32'b0100);
        end
        repeat (4) cycle(4'b0000, 32'h0, 4'b0000);
        chk("solo_rsp_count", 32'(rsp_log.size()), 32'd5);
        foreach (rsp_log[k]) chk("solo_rsp", 32'(rsp_log[k]), 32'(KAT_Y1));

        // Reset with two bytes in flight; nothing may come back.
        cycle(4'b0011, 32'h0000_5301, 4'b0000);
        cycle(4'b0011, 32'h0000_5301, 4'b0000);
        do_reset();
        repeat (4) cycle(4'b0000, 32'h0, 4'b0000);
        cycle(4'b1010, 32'h1122_3344, 4'b0000);
        chk("post_rst_grant", 32'(last_ready), 32'b0010);
        repeat (4) cycle(4'b0000, 32'h0, 4'b0000);

`ifdef GF_SBOX_ARB_INV_EN
        // Inverse S-box byte from requester 1.
        last_rsp_v = '0;
        last_rsp_d = 8'hAA;
        cycle(4'b0010, {16'h0, KAT_IX0, 8'h00}, 4'b0010);
        @(posedge clk);
        #1;
        chk("inv_sbox_x", 32'(sbox_x), 32'(KAT_IX0));
        chk("inv_flag", 32'(sbox_inv), 32'h1);
        repeat (4) cycle(4'b0000, 32'h0, 4'b0000);
        chk("inv_rsp_v", 32'(last_rsp_v), 32'b0010);
        chk("inv_rsp_d", 32'(last_rsp_d), 32'(KAT_IY0));
`endif

        // Random traffic against the scoreboard.
        for (int k = 0; k < 10000; k++) begin
            cycle(4'($urandom_range(0, 15)), $urandom, 4'($urandom));
        end
        repeat (5) cycle(4'b0000, 32'h0, 4'b0000);
        chk("drained", 32'(q.size()), 32'h0);
        chk("max_wait_lt_nreq", 32'(max_wait < NREQ), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
